dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and performs the access on an internal word-organised array after a programmable latency.
- Returns read data and an error flag over a second valid/ready handshake.
- Read data is always the full aligned word. The execute stage does byte selection (lbu) and drives lane-aligned store data and masks.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request accept edge to resp_valid assertion; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  32  byte address; bits [1:0] ignored for indexing.
- req_wen  in  1  1 = store, 0 = load.
- req_wdata  in  32  lane-aligned store data.
- req_wmask  in  4  byte-lane write enables; bit i -> bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator takes response.
- resp_rdata  out  32  aligned word read (0 for stores and errors).
- resp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

Behaviour:
- Reset (async assert, sync release): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0, captured request regs=0. req_ready=1 while in reset. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at an edge, capture addr/wen/wdata/wmask, load cnt=LATENCY-1, go to WAIT.
- WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access this edge and go to RESP.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable. On resp_ready, go to IDLE and clear resp_valid. resp_rdata and resp_err keep their last value until the next access.
- Timing: request accepted at edge t means resp_valid is high from edge t+LATENCY. Minimum round trip with resp_ready tied high is LATENCY+1 cycles. The next request is accepted no earlier than the edge after the response handshake (no overlap, no back-to-back acceptance).
- Address decode: off = addr - BASE_ADDR. In range iff addr >= BASE_ADDR and off < 4*DEPTH_WORDS. Index = off[log2(DEPTH_WORDS)+1:2].
- Load in range: resp_rdata = array[index], resp_err=0. wmask is ignored.
- Store in range: each lane with wmask bit set takes the matching lane of wdata; other lanes are unchanged. resp_rdata=0, resp_err=0.
- wmask=0 on a store: no array change; normal response.
- Out of range (load or store): no array write, resp_rdata=0, resp_err=1.
- Addresses near 2^32 wrap: the subtraction is 32-bit, so addresses below BASE_ADDR yield a large off and report an error.
- Store followed by load to the same word returns the new data (write commits at the WAIT->RESP edge).
- req_valid held high during WAIT/RESP is ignored; the request is taken only in IDLE.
- Initiator input changes after acceptance have no effect, because the request is captured.
- Reset asserted in WAIT: the pending store is dropped and the array is unchanged.
- Reset asserted in RESP: the response is lost and resp_valid drops immediately.
- LATENCY outside 1..15 is an elaboration error.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/RESP), default BASE_ADDR constant, lane-width constant (8), and a function expanding a 4-bit mask to a 32-bit bit mask.
- No sub-module. The array, decode and FSM stay in one module (the array is inferred as register memory).

Test Plan:
- Reset then idle: rst_n low mid-cycle -> resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 immediately. After release, the FSM idles.
- Word store then load (LATENCY=1): store 0x8000_0010 wdata=0xDEADBEEF, wmask=0xF, resp_ready=1 -> resp_valid one cycle after accept, err=0. Load 0x8000_0012 -> rdata=0xDEADBEEF.
- Byte store: on word 0xDEADBEEF, store wdata=0x00AB0000, wmask=0x4 -> load returns 0xDEABBEEF. wmask=0 store -> word unchanged.
- Backpressure (LATENCY=3): resp_ready low for 5 cycles -> resp_valid asserted at accept+3 and held with stable rdata. req_ready=0 throughout, and a second req_valid is not accepted until the cycle after the handshake.
- Out of range: load 0x7FFF_FFFC, store 0x8000_1000 (DEPTH_WORDS=1024) -> resp_err=1, rdata=0, array unchanged (verified by readback).
- Reset mid-op (LATENCY=4): store accepted, rst_n pulsed low 2 cycles later -> resp_valid=0. After release, readback shows the original data.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants and helpers for the data-memory responder:
// FSM encoding, default base address and byte-lane mask expansion.
package dmem_responder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
   localparam int          LANE_W        = 8;

   // Turns a 4-bit byte-lane enable into a 32-bit per-bit write mask.
   function automatic logic [31:0] expand_mask(input logic [3:0] i_mask);
      logic [31:0] v_bits;
      v_bits = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         v_bits[i*LANE_W +: LANE_W] = {LANE_W{i_mask[i]}};
      end
      return v_bits;
   endfunction

endpackage

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: captures one request, waits a
// programmable latency, performs the word access and holds the response.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          LATENCY     = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_wmask,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("dmem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   logic [1:0]    r_state;
   logic [3:0]    r_cnt;
   logic          r_req_ready;
   logic [31:0]   r_addr;
   logic          r_wen;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wmask;
   logic          r_resp_valid;
   logic [31:0]   r_resp_rdata;
   logic          r_resp_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic [31:0]   w_off;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_do_access;
   logic [31:0]   w_mask_bits;

   // Decode works on the captured address; the 32-bit subtraction makes
   // addresses below the base wrap to a large offset and fail the check.
   assign w_off       = r_addr - BASE_ADDR;
   assign w_in_range  = (r_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
   assign w_idx       = w_off[AW+1:2];
   assign w_do_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_mask_bits = expand_mask(r_wmask);

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

   // Array write port: lane-merged store commits on the WAIT->RESP edge.
   always_ff @(posedge i_clk) begin
      if (w_do_access && r_wen && w_in_range) begin
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask_bits) | (r_wdata & w_mask_bits);
      end
   end

   // Request capture, latency count and response handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_req_ready  <= 1'b1;
         r_addr       <= 32'h0000_0000;
         r_wen        <= 1'b0;
         r_wdata      <= 32'h0000_0000;
         r_wmask      <= 4'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_addr      <= i_req_addr;
                  r_wen       <= i_req_wen;
                  r_wdata     <= i_req_wdata;
                  r_wmask     <= i_req_wmask;
                  r_cnt       <= 4'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= ~w_in_range;
                  r_resp_rdata <= (!r_wen && w_in_range) ? r_mem[w_idx] : 32'h0000_0000;
                  r_state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder: three instances with
// LATENCY 1, 3 and 4 checked against a word-level memory model.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr [3];
   logic [31:0] req_wdata [3];
   logic [31:0] resp_rdata [3];
   logic [3:0]  req_wmask [3];

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .LATENCY    (g == 0 ? 1 : (g == 1 ? 3 : 4))
         ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wen   (req_wen[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_wmask (req_wmask[g]),
            .o_resp_valid(resp_valid[g]),
            .i_resp_ready(resp_ready[g]),
            .o_resp_rdata(resp_rdata[g]),
            .o_resp_err  (resp_err[g])
         );
      end
   endgenerate

   function automatic int lat_of(int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   function automatic bit in_range(logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return (addr >= BASE) && (off < 32'(DEPTH * 4));
   endfunction

   function automatic int key_of(int d, logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return d * 4096 + int'(off[11:2]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full transaction on instance d; model computes the expected response.
   task automatic txn(int d, logic [31:0] addr, logic wen, logic [31:0] wdata,
                      logic [3:0] wmask, int hold, bit keep_valid);
      logic [31:0] exp_rdata, word;
      logic        exp_err;
      int          k;
      exp_rdata = 32'h0;
      exp_err   = !in_range(addr);
      if (!exp_err) begin
         word = mdl.exists(key_of(d, addr)) ? mdl[key_of(d, addr)] : 32'h0;
         if (wen) begin
            for (int b = 0; b < 4; b++)
               if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
            mdl[key_of(d, addr)] = word;
         end else begin
            exp_rdata = word;
         end
      end
      @(negedge clk);
      chk("req_ready_idle", req_ready[d], 1'b1);
      req_valid[d]  = 1'b1;
      req_addr[d]   = addr;
      req_wen[d]    = wen;
      req_wdata[d]  = wdata;
      req_wmask[d]  = wmask;
      resp_ready[d] = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_wmask[d] = 4'($urandom);
      req_wen[d]   = 1'($urandom);
      req_valid[d] = keep_valid;
      k = 0;
      while (resp_valid[d] !== 1'b1 && k < 20) begin
         chk("req_ready_busy", req_ready[d], 1'b0);
         @(negedge clk);
         k++;
      end
      chk("latency", k, lat_of(d));
      chk("resp_rdata", resp_rdata[d], exp_rdata);
      chk("resp_err", resp_err[d], exp_err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", resp_valid[d], 1'b1);
         chk("hold_rdata", resp_rdata[d], exp_rdata);
         chk("hold_req_ready", req_ready[d], 1'b0);
      end
      resp_ready[d] = 1'b1;
      @(negedge clk);
      chk("valid_clear", resp_valid[d], 1'b0);
      chk("ready_back", req_ready[d], 1'b1);
      chk("rdata_kept", resp_rdata[d], exp_rdata);
      chk("err_kept", resp_err[d], exp_err);
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] a;
      int          k;
      rst_n      = 1'b1;
      req_valid  = 3'b000;
      req_wen    = 3'b000;
      resp_ready = 3'b000;
      for (int d = 0; d < 3; d++) begin
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         req_wmask[d] = 4'h0;
      end
      #23 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_resp_valid", resp_valid[d], 1'b0);
         chk("rst_resp_rdata", resp_rdata[d], 32'h0);
         chk("rst_resp_err", resp_err[d], 1'b0);
         chk("rst_req_ready", req_ready[d], 1'b1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("idle_req_ready", req_ready[d], 1'b1);
         chk("idle_resp_valid", resp_valid[d], 1'b0);
      end

      // Word, byte and empty-mask stores on the LATENCY=1 instance.
      txn(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
      txn(0, 32'h8000_0012, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      txn(0, 32'h8000_0010, 1'b1, 32'h00AB_0000, 4'h4, 0, 1'b0);
      txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      txn(0, 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
      txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0);

      // Out-of-range accesses must not alias onto real words.
      txn(0, 32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0);
      txn(0, 32'h8000_0FFC, 1'b1, 32'h8765_4321, 4'hF, 0, 1'b0);
      txn(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      txn(0, 32'h8000_1000, 1'b1, 32'hBAD0_BAD0, 4'hF, 0, 1'b0);
      txn(0, 32'hFFFF_FFFC, 1'b1, 32'hBAD1_BAD1, 4'hF, 0, 1'b0);
      txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
      txn(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 0, 1'b0);

      // Backpressure on LATENCY=3 with req_valid held through the response.
      txn(1, 32'h8000_0020, 1'b1, 32'hA5A5_5A5A, 4'hF, 2, 1'b1);
      txn(1, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 5, 1'b1);

      // Reset while a store waits on LATENCY=4: the store must be dropped.
      txn(2, 32'h8000_0040, 1'b1, 32'h1122_3344, 4'hF, 0, 1'b0);
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_addr[2]  = 32'h8000_0040;
      req_wen[2]   = 1'b1;
      req_wdata[2] = 32'hCAFE_F00D;
      req_wmask[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wait_valid", resp_valid[2], 1'b0);
      chk("rst_wait_ready", req_ready[2], 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txn(2, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, 1'b0);

      // Reset while a response is pending: valid drops without a clock.
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h8000_0020;
      req_wen[1]   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      k = 0;
      while (resp_valid[1] !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("resp_pending_latency", k, 3);
      rst_n = 1'b0;
      #1;
      chk("rst_resp_drop_valid", resp_valid[1], 1'b0);
      chk("rst_resp_drop_rdata", resp_rdata[1], 32'h0);
      chk("rst_resp_drop_ready", req_ready[1], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic on a small window of pre-initialised words.
      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 16; w++)
            txn(d, BASE + 32'(w * 4), 1'b1, $urandom, 4'hF, 0, 1'b0);
         for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
               0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 65535));
               1:       a = BASE - 32'd1 - 32'($urandom_range(0, 65535));
               default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            endcase
            txn(d, a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                1'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
